// File: rtl/vga_input_status_packer.sv
// rtl/vga_input_status_packer.sv - synchronized, debounced key/switch/vsync status word for the input PIO
// Keys and switches are debounced; vsync is only synchronized and edge-counted.
module vga_input_status_packer #(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter bit KEY_ACTIVE_LOW   = 1'b1,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_raw,
  input  logic [9:0]  sw_raw,
  input  logic        vsync_raw,
  output logic [31:0] status_word
);

  localparam int NB = 14;
  localparam int CW = 20;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0] w_norm;
  logic          w_vs_norm;
  logic [NB-1:0] r_s1, r_s2, r_deb;
  logic          r_vs_s1, r_vs_s2;
  logic [CW-1:0] r_cnt [NB];
  logic [CW-1:0] w_cnt_next [NB];
  logic [NB-1:0] w_deb_next;
  logic [3:0]    w_press;
  logic [2:0]    w_npress;
  logic          w_vs_rise;
  logic [7:0]    r_kcnt, r_frame;
  logic          r_toggle;

  // Bit order keeps keys in [3:0] so the debounced vector maps straight onto status[13:0].
  assign w_norm    = {sw_raw, (KEY_ACTIVE_LOW ? ~key_raw : key_raw)};
  assign w_vs_norm = VSYNC_ACTIVE_LOW ? ~vsync_raw : vsync_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_vs_s1 <= 1'b0;
      r_vs_s2 <= 1'b0;
    end else begin
      r_s1    <= w_norm;
      r_s2    <= r_s1;
      r_vs_s1 <= w_vs_norm;
      r_vs_s2 <= r_vs_s1;
    end
  end

  always_comb begin
    w_deb_next = r_deb;
    for (int i = 0; i < NB; i++) begin
      w_cnt_next[i] = '0;
      if (r_s2[i] != r_deb[i]) begin
        if (r_cnt[i] == C_LAST) begin
          w_deb_next[i] = r_s2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Press and change detection look at the next debounced value so the counters
  // land in the same status update as the debounced bits themselves.
  assign w_press   = w_deb_next[3:0] & ~r_deb[3:0];
  assign w_vs_rise = r_vs_s1 & ~r_vs_s2;

  always_comb begin
    w_npress = '0;
    for (int k = 0; k < 4; k++) begin
      w_npress = w_npress + {2'b00, w_press[k]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb    <= '0;
      r_kcnt   <= '0;
      r_frame  <= '0;
      r_toggle <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_deb  <= w_deb_next;
      r_kcnt <= r_kcnt + {5'b00000, w_npress};
      if (w_vs_rise) begin
        r_frame <= r_frame + 8'd1;
      end
      if (|(w_deb_next ^ r_deb)) begin
        r_toggle <= ~r_toggle;
      end
      for (int i = 0; i < NB; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_word <= 32'h0;
    end else begin
      status_word <= {r_toggle, r_vs_s2, r_kcnt, r_frame, r_deb};
    end
  end

endmodule

// File: tb/tb_vga_input_status_packer.sv
// tb/tb_vga_input_status_packer.sv - directed and table-driven checks of the status packer
module tb_vga_input_status_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  key_raw = 4'hF;
  logic [9:0]  sw_raw = 10'h000;
  logic        vsync_raw = 1'b1;
  logic [31:0] status_word;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [13:0] deb;
    logic [7:0]  kcnt;
    logic        tog;
  } vec_t;

  vec_t tbl [6];

  vga_input_status_packer #(
    .DEBOUNCE_CYCLES(4),
    .KEY_ACTIVE_LOW(1'b1),
    .VSYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
    .sw_raw(sw_raw),
    .vsync_raw(vsync_raw),
    .status_word(status_word)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic tog, input logic vs, input logic [7:0] kc,
                                     input logic [7:0] fr, input logic [13:0] deb);
    return {tog, vs, kc, fr, deb};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{key: 4'hF, sw: 10'h000, deb: 14'h0000, kcnt: 8'd0, tog: 1'b0};
    tbl[1] = '{key: 4'hE, sw: 10'h2A5, deb: 14'h2A51, kcnt: 8'd1, tog: 1'b1};
    tbl[2] = '{key: 4'hC, sw: 10'h155, deb: 14'h1553, kcnt: 8'd2, tog: 1'b0};
    tbl[3] = '{key: 4'h0, sw: 10'h3FF, deb: 14'h3FFF, kcnt: 8'd4, tog: 1'b1};
    tbl[4] = '{key: 4'hF, sw: 10'h000, deb: 14'h0000, kcnt: 8'd4, tog: 1'b0};
    tbl[5] = '{key: 4'h5, sw: 10'h001, deb: 14'h001A, kcnt: 8'd6, tog: 1'b1};

    tick(1);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      check("idle_zero", status_word, 32'h0);
      tick(1);
    end

    // Single key press then release, exact 7-edge latency.
    key_raw = 4'hE;
    tick(6);
    check("key0_press_early", status_word, 32'h0);
    tick(1);
    check("key0_press", status_word, mk(1'b1, 1'b0, 8'd1, 8'd0, 14'h0001));
    key_raw = 4'hF;
    tick(6);
    check("key0_release_early", status_word, mk(1'b1, 1'b0, 8'd1, 8'd0, 14'h0001));
    tick(1);
    check("key0_release", status_word, mk(1'b0, 1'b0, 8'd1, 8'd0, 14'h0000));

    // Bouncing key1: low 3, high 1, low held.
    key_raw = 4'hD;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("bounce_hold", status_word, mk(1'b0, 1'b0, 8'd1, 8'd0, 14'h0000));
    end
    key_raw = 4'hF;
    tick(1);
    check("bounce_hold", status_word, mk(1'b0, 1'b0, 8'd1, 8'd0, 14'h0000));
    key_raw = 4'hD;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("bounce_wait", status_word, mk(1'b0, 1'b0, 8'd1, 8'd0, 14'h0000));
    end
    tick(1);
    check("bounce_accept", status_word, mk(1'b1, 1'b0, 8'd2, 8'd0, 14'h0002));
    key_raw = 4'hF;
    tick(10);
    check("bounce_release", status_word, mk(1'b0, 1'b0, 8'd2, 8'd0, 14'h0000));

    // Bring the count to 254 with all-four presses, then wrap.
    for (int i = 0; i < 63; i++) begin
      key_raw = 4'h0;
      tick(10);
      key_raw = 4'hF;
      tick(10);
    end
    check("count_254", status_word, mk(1'b0, 1'b0, 8'd254, 8'd0, 14'h0000));
    key_raw = 4'h0;
    tick(6);
    check("wrap_early", status_word, mk(1'b0, 1'b0, 8'd254, 8'd0, 14'h0000));
    tick(1);
    check("wrap_all4", status_word, mk(1'b1, 1'b0, 8'd2, 8'd0, 14'h000F));
    key_raw = 4'hF;
    tick(10);
    check("wrap_release", status_word, mk(1'b0, 1'b0, 8'd2, 8'd0, 14'h0000));

    // 260 vsync pulses: bit 30 and frame count 3 edges after the raw falling edge.
    for (int p = 0; p < 260; p++) begin
      vsync_raw = 1'b0;
      tick(2);
      check("vsync_early", status_word, mk(1'b0, 1'b0, 8'd2, 8'(p), 14'h0000));
      vsync_raw = 1'b1;
      tick(1);
      check("vsync_edge", status_word, mk(1'b0, 1'b1, 8'd2, 8'(p + 1), 14'h0000));
      tick(9);
    end
    check("frame_wrap", {24'h0, status_word[21:14]}, 32'd4);

    // Reset mid-debounce with a switch pattern and key0 held throughout.
    sw_raw  = 10'h2A5;
    key_raw = 4'hE;
    tick(2);
    reset = 1'b1;
    #1;
    check("reset_async", status_word, 32'h0);
    tick(2);
    check("reset_held", status_word, 32'h0);
    reset = 1'b0;
    tick(6);
    check("post_reset_early", status_word, 32'h0);
    tick(1);
    check("post_reset_accept", status_word, mk(1'b1, 1'b0, 8'd1, 8'd0, {10'h2A5, 4'b0001}));

    sw_raw  = 10'h000;
    key_raw = 4'hF;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      key_raw = tbl[i].key;
      sw_raw  = tbl[i].sw;
      tick(10);
      check($sformatf("table_%0d", i), status_word,
            mk(tbl[i].tog, 1'b0, tbl[i].kcnt, 8'd0, tbl[i].deb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
